sim_run_ctrl: RTL

//  Single-clock run/finish controller for the simulation top level.
//  - Sequences the design reset: holds the DUT in reset for a fixed cycle count, then releases it.
//  - Turns the testbench finish request into a clean, drained, sticky finish indication.
//  - Optionally enforces a cycle-count watchdog.

---
 rtl/sim_run_ctrl_pkg.sv | 21 ++
 rtl/sim_sat_counter.sv | 33 +++
 rtl/sim_run_ctrl.sv | 135 +++++++++++++
 3 files changed

// File: rtl/sim_run_ctrl_pkg.sv
// Shared types and default parameter values for the simulation run/finish controller.
package sim_run_ctrl_pkg;

    typedef enum logic [1:0] {
        HOLD  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } sim_run_state_t;

    localparam int unsigned DEF_RESET_CYCLES    = 20;
    localparam int unsigned DEF_DRAIN_CYCLES    = 4;
    localparam int unsigned DEF_CYCLE_W         = 32;
    localparam int unsigned DEF_WATCHDOG_CYCLES = 1000000;

    // Bits needed to hold 0..max_val; never narrower than one bit.
    function automatic int unsigned cnt_width(input int unsigned max_val);
        return (max_val == 0) ? 1 : $clog2(max_val + 1);
    endfunction

endpackage

// File: rtl/sim_sat_counter.sv
// Free-running cycle counter that sticks at all-ones instead of wrapping.
module sim_sat_counter
    import sim_run_ctrl_pkg::*;
#(
    parameter int unsigned W = DEF_CYCLE_W
) (
    input  logic         CLK,
    input  logic         RST,
    input  logic         inc,
    output logic [W-1:0] q
);

    logic [W-1:0] q_d;
    logic [W-1:0] q_q;

    always_comb begin
        q_d = q_q;
        if (inc && (q_q != '1)) begin
            q_d = q_q + W'(1);
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            q_q <= '0;
        end else begin
            q_q <= q_d;
        end
    end

    assign q = q_q;

endmodule

// File: rtl/sim_run_ctrl.sv
// Reset sequencer and drained, sticky finish controller for the simulation top.
// Optional cycle watchdog enabled by defining SIM_RUN_WATCHDOG_EN.
module sim_run_ctrl
    import sim_run_ctrl_pkg::*;
#(
    parameter int unsigned RESET_CYCLES    = DEF_RESET_CYCLES,
    parameter int unsigned DRAIN_CYCLES    = DEF_DRAIN_CYCLES,
    parameter int unsigned CYCLE_W         = DEF_CYCLE_W,
    parameter int unsigned WATCHDOG_CYCLES = DEF_WATCHDOG_CYCLES
) (
    input  logic               CLK,
    input  logic               RST,
    input  logic               finish_req,
    output logic               RST_N_design,
    output logic               run,
    output logic               finish,
    output logic               timeout,
    output logic [CYCLE_W-1:0] cycle_count
);

    localparam int unsigned HOLD_W  = cnt_width(RESET_CYCLES);
    localparam int unsigned DRAIN_W = cnt_width(DRAIN_CYCLES);

    sim_run_state_t     state_q, state_d;
    logic [HOLD_W-1:0]  hold_q, hold_d;
    logic [DRAIN_W-1:0] drain_q, drain_d;
    logic               rstn_q, rstn_d;
    logic               run_q, run_d;
    logic               finish_q, finish_d;
    logic               timeout_q, timeout_d;
    logic [CYCLE_W-1:0] cnt_q;
    logic               wd_hit_c;

    sim_sat_counter #(
        .W (CYCLE_W)
    ) u_cycle_cnt (
        .CLK (CLK),
        .RST (RST),
        .inc (1'b1),
        .q   (cnt_q)
    );

    // Watchdog fires on the edge where the cycle count reaches its limit.
`ifdef SIM_RUN_WATCHDOG_EN
    assign wd_hit_c = (cnt_q != '1) &&
                      ((64'(cnt_q) + 64'd1) == 64'(WATCHDOG_CYCLES));
`else
    logic unused_wd_c;
    assign wd_hit_c    = 1'b0;
    assign unused_wd_c = ^32'(WATCHDOG_CYCLES);
`endif

    always_comb begin
        state_d   = state_q;
        hold_d    = hold_q;
        drain_d   = drain_q;
        rstn_d    = rstn_q;
        run_d     = run_q;
        finish_d  = finish_q;
        timeout_d = timeout_q;
        case (state_q)
            HOLD: begin
                hold_d = hold_q + HOLD_W'(1);
                if (wd_hit_c) begin
                    state_d   = DONE;
                    finish_d  = 1'b1;
                    timeout_d = 1'b1;
                end else if (hold_q == HOLD_W'(RESET_CYCLES - 1)) begin
                    state_d = RUN;
                    rstn_d  = 1'b1;
                    run_d   = 1'b1;
                end
            end
            RUN: begin
                // A request on the watchdog edge still takes the drained path.
                if (finish_req) begin
                    run_d = 1'b0;
                    if (DRAIN_CYCLES == 0) begin
                        state_d  = DONE;
                        finish_d = 1'b1;
                    end else begin
                        state_d = DRAIN;
                        drain_d = DRAIN_W'(DRAIN_CYCLES);
                    end
                end else if (wd_hit_c) begin
                    state_d   = DONE;
                    run_d     = 1'b0;
                    finish_d  = 1'b1;
                    timeout_d = 1'b1;
                end
            end
            DRAIN: begin
                if (drain_q == '0) begin
                    state_d  = DONE;
                    finish_d = 1'b1;
                end else begin
                    drain_d = drain_q - DRAIN_W'(1);
                end
            end
            DONE: begin
                state_d = DONE;
            end
            default: begin
                state_d = HOLD;
            end
        endcase
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q   <= HOLD;
            hold_q    <= '0;
            drain_q   <= '0;
            rstn_q    <= 1'b0;
            run_q     <= 1'b0;
            finish_q  <= 1'b0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            hold_q    <= hold_d;
            drain_q   <= drain_d;
            rstn_q    <= rstn_d;
            run_q     <= run_d;
            finish_q  <= finish_d;
            timeout_q <= timeout_d;
        end
    end

    assign RST_N_design = rstn_q;
    assign run          = run_q;
    assign finish       = finish_q;
    assign timeout      = timeout_q;
    assign cycle_count  = cnt_q;

endmodule
